// File: rtl/ssram_arbiter.sv
// ssram_arbiter: framebuffer-priority, starvation-bounded arbiter with a registered request stage to ssram_ctrl
module ssram_arbiter #(
  parameter logic [1:0] ID_FB        = 2'd3,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [29:0] fb_address,
  input  logic        fb_read,
  output logic        fb_waitrequest,
  input  logic [1:0]  cpu_id,
  input  logic [29:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_writedatamask,
  output logic        cpu_waitrequest,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask
);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;
  logic       can_load, cpu_req, grant_cpu, grant_fb;
  always_comb begin
    can_load        = !(mem_read | mem_write) | !mem_waitrequest;
    cpu_req         = cpu_read | cpu_write;
    grant_cpu       = cpu_req & (!fb_read | starve_cnt == LIMIT);
    grant_fb        = fb_read & !grant_cpu;
    fb_waitrequest  = !(reset_n & grant_fb & can_load);
    cpu_waitrequest = !(reset_n & grant_cpu & can_load);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mem_id            <= '0;
      mem_address       <= '0;
      mem_read          <= 1'b0;
      mem_write         <= 1'b0;
      mem_writedata     <= '0;
      mem_writedatamask <= '0;
      starve_cnt        <= '0;
    end else if (can_load) begin
      if (grant_cpu) begin
        mem_id            <= cpu_id;
        mem_address       <= cpu_address;
        mem_read          <= cpu_read & !cpu_write;
        mem_write         <= cpu_write;
        mem_writedata     <= cpu_writedata;
        mem_writedatamask <= cpu_writedatamask;
        starve_cnt        <= '0;
      end else if (grant_fb) begin
        mem_id      <= ID_FB;
        mem_address <= fb_address;
        mem_read    <= 1'b1;
        mem_write   <= 1'b0;
        starve_cnt  <= cpu_req && starve_cnt != LIMIT ? starve_cnt + 8'd1 : starve_cnt;
      end else begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ssram_arbiter.sv
// tb_ssram_arbiter: scoreboard bench for ssram_arbiter
module tb_ssram_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [29:0] fb_address;
  logic        fb_read;
  logic        fb_waitrequest;
  logic [1:0]  cpu_id;
  logic [29:0] cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_writedatamask;
  logic        cpu_waitrequest;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  typedef struct {
    logic [1:0]  id;
    logic [29:0] a;
    logic        r;
    logic        w;
    logic [31:0] d;
    logic [3:0]  m;
  } txn_t;
  txn_t q[$];
  int checks = 0, failures = 0, cnt = 0, cpu_acc = 0, fb_acc = 0;
  logic [31:0] last_d = '0;
  logic [3:0]  last_m = '0;
  ssram_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .fb_address(fb_address), .fb_read(fb_read), .fb_waitrequest(fb_waitrequest),
    .cpu_id(cpu_id), .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_writedatamask(cpu_writedatamask), .cpu_waitrequest(cpu_waitrequest),
    .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    logic cr, valid, cl, gc, gf;
    txn_t t;
    @(negedge clock);
    cr    = cpu_read | cpu_write;
    valid = q.size() != 0;
    cl    = !valid | !mem_waitrequest;
    gc    = cr & (!fb_read | cnt == 8);
    gf    = fb_read & !gc;
    chk("fb_waitrequest", 64'(fb_waitrequest), 64'(!(gf & cl)));
    chk("cpu_waitrequest", 64'(cpu_waitrequest), 64'(!(gc & cl)));
    if (valid & !mem_waitrequest) void'(q.pop_front());
    if (cl & gc) begin
      t = '{cpu_id, cpu_address, !cpu_write, cpu_write, cpu_writedata, cpu_writedatamask};
      last_d = cpu_writedata;
      last_m = cpu_writedatamask;
      q.push_back(t);
      cnt = 0;
      cpu_acc++;
    end else if (cl & gf) begin
      t = '{2'd3, fb_address, 1'b1, 1'b0, last_d, last_m};
      q.push_back(t);
      if (cr && cnt < 8) cnt++;
      fb_acc++;
    end
    @(posedge clock);
    #1;
    chk("starve_cnt", 64'(dut.starve_cnt), 64'(cnt));
    if (q.size() != 0) begin
      t = q[0];
      chk("mem_id", 64'(mem_id), 64'(t.id));
      chk("mem_address", 64'(mem_address), 64'(t.a));
      chk("mem_read", 64'(mem_read), 64'(t.r));
      chk("mem_write", 64'(mem_write), 64'(t.w));
      chk("mem_writedata", 64'(mem_writedata), 64'(t.d));
      chk("mem_writedatamask", 64'(mem_writedatamask), 64'(t.m));
    end else
      chk("mem_idle", 64'({mem_read, mem_write}), 64'(0));
  endtask
  initial begin
    reset_n = 1'b0;
    fb_address = '0; fb_read = 1'b0;
    cpu_id = '0; cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = '0; cpu_writedatamask = '0; mem_waitrequest = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outputs", 64'({mem_id, mem_read, mem_write, mem_writedatamask}), 64'(0));
    chk("rst_addr_data", 64'({mem_address, mem_writedata}), 64'(0));
    chk("rst_waits", 64'({fb_waitrequest, cpu_waitrequest}), 64'(3));
    reset_n = 1'b1;
    repeat (2) cycle();
    fb_read = 1'b1; fb_address = 30'h40000;
    repeat (4) cycle();
    fb_read = 1'b0;
    cycle();
    cpu_write = 1'b1; cpu_id = 2'd1; cpu_address = 30'h123;
    cpu_writedata = 32'hDEADBEEF; cpu_writedatamask = 4'b0011;
    cycle();
    cpu_write = 1'b0;
    cycle();
    cpu_read = 1'b1; cpu_id = 2'd2; cpu_address = 30'h200;
    cycle();
    cpu_address = 30'h201; fb_read = 1'b1; fb_address = 30'h7; mem_waitrequest = 1'b1;
    repeat (5) cycle();
    mem_waitrequest = 1'b0;
    cycle();
    fb_read = 1'b0;
    cycle();
    cpu_read = 1'b0;
    cycle();
    fb_read = 1'b1; cpu_read = 1'b1; cpu_address = 30'h300; fb_address = 30'h400;
    cpu_acc = 0; fb_acc = 0;
    for (int i = 0; i < 27; i++) begin
      fb_address = 30'h400 + 30'(i);
      cycle();
    end
    chk("starve_cpu_accepts", 64'(cpu_acc), 64'(3));
    chk("starve_fb_accepts", 64'(fb_acc), 64'(24));
    fb_read = 1'b0; cpu_read = 1'b0;
    cycle();
    fb_read = 1'b1; cpu_write = 1'b1; cpu_address = 30'h55; cpu_writedata = 32'h12345678; cpu_writedatamask = 4'hF;
    cycle();
    chk("tie_cpu_wait_cnt", 64'(dut.starve_cnt), 64'(1));
    fb_read = 1'b0;
    cpu_acc = 0;
    cycle();
    chk("tie_cpu_accepted", 64'(cpu_acc), 64'(1));
    cpu_write = 1'b0; fb_read = 1'b1; fb_address = 30'h99;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_strobes", 64'({mem_read, mem_write}), 64'(0));
    chk("rst_async_waits", 64'({fb_waitrequest, cpu_waitrequest}), 64'(3));
    q.delete();
    cnt = 0;
    last_d = '0; last_m = '0;
    fb_read = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
